// File: rtl/ps2_kb_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// scan codes of interest and the HID keycodes they translate to.
package ps2_kb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_W     = 8'h1D;

   localparam logic [7:0] HID_NONE = 8'h00;
   localparam logic [7:0] HID_A    = 8'h04;
   localparam logic [7:0] HID_D    = 8'h07;
   localparam logic [7:0] HID_S    = 8'h16;
   localparam logic [7:0] HID_W    = 8'h1A;

   function automatic logic [7:0] scan_to_hid(input logic [7:0] sc);
      logic [7:0] hid;
      case (sc)
         SC_A:    hid = HID_A;
         SC_D:    hid = HID_D;
         SC_S:    hid = HID_S;
         SC_W:    hid = HID_W;
         default: hid = HID_NONE;
      endcase
      return hid;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, samples on falling edges of
// the keyboard clock and checks start, odd parity and stop bits.
module ps2_frame_rx
   import ps2_kb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]       r_clk_sync;
   logic [1:0]       r_data_sync;
   logic             r_clk_prev;
   frame_state_t     r_state;
   logic [7:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic             r_err;
   logic [CNT_W-1:0] r_idle_cnt;

   logic w_fall;
   logic w_bit;
   logic w_timeout;

   assign w_fall    = r_clk_prev & ~r_clk_sync[1];
   assign w_bit     = r_data_sync[1];
   assign w_timeout = (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
         r_data_sync <= {r_data_sync[0], i_ps2_data};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_shift      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_err        <= 1'b0;
         r_idle_cnt   <= '0;
         o_byte       <= 8'h00;
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         if (r_state != ST_IDLE && !w_fall && w_timeout) begin
            r_state     <= ST_IDLE;
            r_idle_cnt  <= '0;
            o_frame_err <= 1'b1;
         end else if (w_fall) begin
            r_idle_cnt <= '0;
            case (r_state)
               ST_IDLE: begin
                  if (!w_bit) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= 3'd0;
                     r_err     <= 1'b0;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {w_bit, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  r_err   <= ~(^{r_shift, w_bit});
                  r_state <= ST_STOP;
               end
               ST_STOP: begin
                  if (w_bit && !r_err) begin
                     o_byte       <= r_shift;
                     o_byte_valid <= 1'b1;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (r_state == ST_IDLE) begin
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard front end: tracks which WASD movement key is held and reports
// it as a HID keycode, pulsing key_valid whenever the reported key changes.
module ps2_keycode_rx
   import ps2_kb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_keycode,
   output logic       o_key_valid,
   output logic       o_frame_err
);

   logic [7:0] w_byte;
   logic       w_byte_valid;
   logic       w_frame_err;
   logic [7:0] w_hid;

   logic [7:0] r_keycode;
   logic       r_key_valid;
   logic       r_ext_pending;
   logic       r_brk_pending;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame_rx (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_ps2_clk   (i_ps2_clk),
      .i_ps2_data  (i_ps2_data),
      .o_byte      (w_byte),
      .o_byte_valid(w_byte_valid),
      .o_frame_err (w_frame_err)
   );

   // Extended codes share scan values with the movement keys but are other keys.
   assign w_hid = r_ext_pending ? HID_NONE : scan_to_hid(w_byte);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_keycode     <= HID_NONE;
         r_key_valid   <= 1'b0;
         r_ext_pending <= 1'b0;
         r_brk_pending <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_frame_err) begin
            r_ext_pending <= 1'b0;
            r_brk_pending <= 1'b0;
         end else if (w_byte_valid) begin
            if (w_byte == SC_EXT) begin
               r_ext_pending <= 1'b1;
            end else if (w_byte == SC_BREAK) begin
               r_brk_pending <= 1'b1;
            end else begin
               r_ext_pending <= 1'b0;
               r_brk_pending <= 1'b0;
               if (w_hid != HID_NONE) begin
                  if (!r_brk_pending && w_hid != r_keycode) begin
                     r_keycode   <= w_hid;
                     r_key_valid <= 1'b1;
                  end else if (r_brk_pending && w_hid == r_keycode) begin
                     r_keycode   <= HID_NONE;
                     r_key_valid <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign o_keycode   = r_keycode;
   assign o_key_valid = r_key_valid;
   assign o_frame_err = w_frame_err;

endmodule
